// File: rtl/undistort_pkg.sv
// Shared definitions for the undistort pipeline: default pixel/fraction widths
// and the accumulator widths of the separable bilinear blend.
package undistort_pkg;

  localparam int DEFAULT_BITS_PER_PIXEL = 8;
  localparam int DEFAULT_FRAC_BITS      = 4;

  typedef enum logic {
    STAGE_H,
    STAGE_V
  } acc_stage_e;

  // Horizontal pass adds one weight factor (0..2^fb); vertical pass adds a second.
  function automatic int acc_width(input acc_stage_e stage, input int bpp, input int fb);
    return (stage == STAGE_H) ? bpp + fb + 1 : bpp + 2 * fb + 2;
  endfunction

endpackage

// File: rtl/frac_fifo.sv
// Synchronous FIFO for fractional weights; accepts a push while full if a pop
// happens in the same cycle.
module frac_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // When full, wr_ptr aliases rd_ptr; the head is read before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bilinear_interp.sv
// Blends each incoming 2x2 pixel quad with its queued fractional weights through
// a 3-stage pipeline (horizontal, vertical, round/clip).
module bilinear_interp
  import undistort_pkg::*;
#(
  parameter int BITS_PER_PIXEL = DEFAULT_BITS_PER_PIXEL,
  parameter int FRAC_BITS      = DEFAULT_FRAC_BITS,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frac_valid,
  input  logic [FRAC_BITS-1:0]      frac_x,
  input  logic [FRAC_BITS-1:0]      frac_y,
  output logic                      frac_ready,
  input  logic [BITS_PER_PIXEL-1:0] pixel_tl,
  input  logic [BITS_PER_PIXEL-1:0] pixel_tr,
  input  logic [BITS_PER_PIXEL-1:0] pixel_bl,
  input  logic [BITS_PER_PIXEL-1:0] pixel_br,
  input  logic                      data_valid,
  output logic [BITS_PER_PIXEL-1:0] pixel_out,
  output logic                      pixel_out_valid,
  output logic                      err_underflow,
  output logic                      err_overflow
);

  localparam int S1_W  = acc_width(STAGE_H, BITS_PER_PIXEL, FRAC_BITS);
  localparam int S2_W  = acc_width(STAGE_V, BITS_PER_PIXEL, FRAC_BITS);
  localparam int WW    = FRAC_BITS + 1;
  localparam int SHIFT = 2 * FRAC_BITS;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [WW-1:0] WEIGHT_ONE = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [S2_W:0] ROUND      = {{(S2_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic [S2_W:0] PIX_MAX    = {{(S2_W + 1 - BITS_PER_PIXEL){1'b0}}, {BITS_PER_PIXEL{1'b1}}};

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          occupancy;
  logic [2*FRAC_BITS-1:0] head;

  logic [FRAC_BITS-1:0]   fx;
  logic [FRAC_BITS-1:0]   fy;
  logic [WW-1:0]          wx;
  logic [WW-1:0]          wx_inv;
  logic [S1_W-1:0]        top_next;
  logic [S1_W-1:0]        bot_next;

  logic                   s1_valid;
  logic [S1_W-1:0]        s1_top;
  logic [S1_W-1:0]        s1_bot;
  logic [FRAC_BITS-1:0]   s1_fy;
  logic [WW-1:0]          wy;
  logic [WW-1:0]          wy_inv;
  logic [S2_W-1:0]        acc_next;

  logic                   s2_valid;
  logic [S2_W-1:0]        s2_acc;
  logic [S2_W:0]          rounded;
  logic [BITS_PER_PIXEL-1:0] clipped;

  frac_fifo #(
    .WIDTH (2 * FRAC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_frac_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (frac_valid),
    .pop   (data_valid),
    .din   ({frac_y, frac_x}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign frac_ready = (occupancy != CW'(FIFO_DEPTH));

  always_comb begin
    // An empty queue degrades to zero weights so the quad passes tl through.
    {fy, fx} = fifo_empty ? '0 : head;
    wx       = WW'(fx);
    wx_inv   = WEIGHT_ONE - wx;
    top_next = S1_W'(pixel_tl) * S1_W'(wx_inv) + S1_W'(pixel_tr) * S1_W'(wx);
    bot_next = S1_W'(pixel_bl) * S1_W'(wx_inv) + S1_W'(pixel_br) * S1_W'(wx);
  end

  always_comb begin
    wy       = WW'(s1_fy);
    wy_inv   = WEIGHT_ONE - wy;
    acc_next = S2_W'(s1_top) * S2_W'(wy_inv) + S2_W'(s1_bot) * S2_W'(wy);
  end

  always_comb begin
    rounded = ({1'b0, s2_acc} + ROUND) >> SHIFT;
    clipped = (rounded > PIX_MAX) ? '1 : rounded[BITS_PER_PIXEL-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_top          <= '0;
      s1_bot          <= '0;
      s1_fy           <= '0;
      s2_valid        <= 1'b0;
      s2_acc          <= '0;
      pixel_out_valid <= 1'b0;
      pixel_out       <= '0;
      err_underflow   <= 1'b0;
      err_overflow    <= 1'b0;
    end else begin
      s1_valid        <= data_valid;
      s1_top          <= top_next;
      s1_bot          <= bot_next;
      s1_fy           <= fy;
      s2_valid        <= s1_valid;
      s2_acc          <= acc_next;
      pixel_out_valid <= s2_valid;
      pixel_out       <= clipped;
      if (data_valid && fifo_empty)                err_underflow <= 1'b1;
      if (frac_valid && fifo_full && !data_valid)  err_overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bilinear_interp.sv
// Randomized bench for bilinear_interp against a queue-based reference model
// that applies the bilinear blend formula directly.
module tb_bilinear_interp;

  localparam int BPP   = 8;
  localparam int FB    = 4;
  localparam int DEPTH = 8;
  localparam int WGT   = 1 << FB;
  localparam int PMAX  = (1 << BPP) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           frac_valid = 1'b0;
  logic [FB-1:0]  frac_x = '0;
  logic [FB-1:0]  frac_y = '0;
  logic           frac_ready;
  logic [BPP-1:0] pixel_tl = '0;
  logic [BPP-1:0] pixel_tr = '0;
  logic [BPP-1:0] pixel_bl = '0;
  logic [BPP-1:0] pixel_br = '0;
  logic           data_valid = 1'b0;
  logic [BPP-1:0] pixel_out;
  logic           pixel_out_valid;
  logic           err_underflow;
  logic           err_overflow;

  always #5 clk = ~clk;

  bilinear_interp #(
    .BITS_PER_PIXEL (BPP),
    .FRAC_BITS      (FB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frac_valid      (frac_valid),
    .frac_x          (frac_x),
    .frac_y          (frac_y),
    .frac_ready      (frac_ready),
    .pixel_tl        (pixel_tl),
    .pixel_tr        (pixel_tr),
    .pixel_bl        (pixel_bl),
    .pixel_br        (pixel_br),
    .data_valid      (data_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .err_underflow   (err_underflow),
    .err_overflow    (err_overflow)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: weight queue, a 3-deep delay line of expected results, sticky flags.
  int q_x[$];
  int q_y[$];
  bit pipe_v[3];
  int pipe_p[3];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  function automatic int interp(input int tl, input int tr, input int bl, input int br,
                                input int fx, input int fy);
    int top, bot, acc, r;
    top = tl * (WGT - fx) + tr * fx;
    bot = bl * (WGT - fx) + br * fx;
    acc = top * (WGT - fy) + bot * fy;
    r   = (acc + (1 << (2 * FB - 1))) / (1 << (2 * FB));
    return (r > PMAX) ? PMAX : r;
  endfunction

  function automatic int rnd(input int n);
    return int'($urandom_range(n - 1, 0));
  endfunction

  task automatic drive_idle();
    frac_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic drive_push(input int fx, input int fy);
    frac_valid = 1'b1;
    frac_x     = FB'(fx);
    frac_y     = FB'(fy);
  endtask

  task automatic drive_quad(input int tl, input int tr, input int bl, input int br);
    data_valid = 1'b1;
    pixel_tl   = BPP'(tl);
    pixel_tr   = BPP'(tr);
    pixel_bl   = BPP'(bl);
    pixel_br   = BPP'(br);
  endtask

  // Advance model by one clock using the currently driven inputs, then clock the DUT.
  task automatic cycle();
    int fx, fy, res;
    bit v;
    if (rst) begin
      q_x.delete();
      q_y.delete();
      for (int i = 0; i < 3; i++) begin
        pipe_v[i] = 1'b0;
        pipe_p[i] = 0;
      end
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      v   = 1'b0;
      res = 0;
      if (data_valid) begin
        if (q_x.size() > 0) begin
          fx = q_x.pop_front();
          fy = q_y.pop_front();
        end else begin
          fx    = 0;
          fy    = 0;
          m_unf = 1'b1;
        end
        v   = 1'b1;
        res = interp(int'(pixel_tl), int'(pixel_tr), int'(pixel_bl), int'(pixel_br), fx, fy);
      end
      if (frac_valid) begin
        if (q_x.size() < DEPTH) begin
          q_x.push_back(int'(frac_x));
          q_y.push_back(int'(frac_y));
        end else begin
          m_ovf = 1'b1;
        end
      end
      pipe_v[2] = pipe_v[1]; pipe_p[2] = pipe_p[1];
      pipe_v[1] = pipe_v[0]; pipe_p[1] = pipe_p[0];
      pipe_v[0] = v;         pipe_p[0] = res;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_push(3, 5);
    drive_quad(1, 2, 3, 4);
    cycle();
    cycle();
    rst = 1'b0;
    drive_idle();
    total++;
    if (pixel_out_valid !== 1'b0 || pixel_out !== '0)
      $display("FAIL reset_out: got valid=%0b pixel=%0d, want valid=0 pixel=0", pixel_out_valid, pixel_out);
    else passed++;
    total++;
    if (err_underflow !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL reset_flags: got unf=%0b ovf=%0b, want 0 0", err_underflow, err_overflow);
    else passed++;
    total++;
    if (frac_ready !== 1'b1)
      $display("FAIL reset_ready: got %0b, want 1", frac_ready);
    else passed++;
    cycle();
    total++;
    if (pixel_out_valid !== 1'b0)
      $display("FAIL reset_idle_valid: got %0b, want 0", pixel_out_valid);
    else passed++;
  endtask

  task automatic test_midpoint();
    drive_push(8, 8);
    cycle();
    drive_idle();
    drive_quad(100, 200, 0, 50);
    cycle();
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (k == 3 && (pixel_out_valid !== 1'b1 || pixel_out !== 8'd88))
        $display("FAIL midpoint_n3: got valid=%0b pixel=%0d, want valid=1 pixel=88", pixel_out_valid, pixel_out);
      else if (k != 3 && pixel_out_valid !== 1'b0)
        $display("FAIL midpoint_n%0d: got valid=%0b, want valid=0", k, pixel_out_valid);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_saturation();
    int got[$];
    drive_push(0, 0);
    cycle();
    drive_push(15, 15);
    cycle();
    drive_idle();
    drive_quad(255, 255, 255, 255);
    cycle();
    cycle();
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL sat_out cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 k, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
      if (pixel_out_valid === 1'b1) got.push_back(int'(pixel_out));
      cycle();
    end
    total++;
    if (got.size() != 2 || got[0] != 255 || got[1] != 255)
      $display("FAIL sat_values: got %0d outputs (%p), want 2 outputs 255 255", got.size(), got);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(rnd(WGT), rnd(WGT));
      cycle();
    end
    total++;
    if (frac_ready !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL ovf_full: got ready=%0b ovf=%0b, want ready=0 ovf=0", frac_ready, err_overflow);
    else passed++;
    drive_push(rnd(WGT), rnd(WGT));
    cycle();
    drive_idle();
    total++;
    if (frac_ready !== 1'b0 || err_overflow !== 1'b1)
      $display("FAIL ovf_drop: got ready=%0b ovf=%0b, want ready=0 ovf=1", frac_ready, err_overflow);
    else passed++;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k < DEPTH) drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
      else drive_idle();
      cycle();
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL ovf_order cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 k, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
    end
    total++;
    if (frac_ready !== 1'b1 || err_overflow !== 1'b1 || err_underflow !== 1'b0)
      $display("FAIL ovf_after: got ready=%0b ovf=%0b unf=%0b, want 1 1 0", frac_ready, err_overflow, err_underflow);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(rnd(WGT), rnd(WGT));
      cycle();
    end
    drive_push(rnd(WGT), rnd(WGT));
    drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
    cycle();
    drive_idle();
    total++;
    if (frac_ready !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL pushpop_full: got ready=%0b ovf=%0b, want ready=0 ovf=0", frac_ready, err_overflow);
    else passed++;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k < DEPTH) drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
      else drive_idle();
      cycle();
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL pushpop_order cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 k, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
    end
    total++;
    if (frac_ready !== 1'b1 || err_underflow !== 1'b0)
      $display("FAIL pushpop_drained: got ready=%0b unf=%0b, want ready=1 unf=0", frac_ready, err_underflow);
    else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    drive_quad(42, rnd(256), rnd(256), rnd(256));
    cycle();
    drive_idle();
    total++;
    if (err_underflow !== 1'b1)
      $display("FAIL unf_flag: got %0b, want 1", err_underflow);
    else passed++;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        total++;
        if (pixel_out_valid !== 1'b1 || pixel_out !== 8'd42)
          $display("FAIL unf_passthru: got valid=%0b pixel=%0d, want valid=1 pixel=42", pixel_out_valid, pixel_out);
        else passed++;
      end
      if (k < 3) cycle();
    end
    // Push coinciding with an empty-queue quad must be stored for the next quad.
    drive_push(rnd(WGT - 1) + 1, rnd(WGT - 1) + 1);
    drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
    cycle();
    frac_valid = 1'b0;
    drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
    cycle();
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL unf_store cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 k, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
      cycle();
    end
    total++;
    if (err_underflow !== 1'b1 || err_overflow !== 1'b0)
      $display("FAIL unf_sticky: got unf=%0b ovf=%0b, want unf=1 ovf=0", err_underflow, err_overflow);
    else passed++;
    do_reset();
    total++;
    if (err_underflow !== 1'b0)
      $display("FAIL unf_cleared: got %0b, want 0", err_underflow);
    else passed++;
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive_idle();
      if (q_x.size() < DEPTH && rnd(4) != 0) drive_push(rnd(WGT), rnd(WGT));
      if (q_x.size() > 0 && rnd(5) != 0) drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
      cycle();
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL b2b_out cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 c, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
    end
    rst = 1'b1;
    drive_push(rnd(WGT), rnd(WGT));
    drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
    cycle();
    rst = 1'b0;
    drive_idle();
    total++;
    if (pixel_out_valid !== 1'b0 || pixel_out !== '0 || err_underflow !== 1'b0 ||
        err_overflow !== 1'b0 || frac_ready !== 1'b1)
      $display("FAIL b2b_reset: got valid=%0b pixel=%0d unf=%0b ovf=%0b ready=%0b, want 0 0 0 0 1",
               pixel_out_valid, pixel_out, err_underflow, err_overflow, frac_ready);
    else passed++;
    cycle();
    drive_push(rnd(WGT), rnd(WGT));
    cycle();
    drive_idle();
    drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
    cycle();
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (pixel_out_valid !== (k == 3) || (k == 3 && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL b2b_post n%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 k, pixel_out_valid, pixel_out, (k == 3), pipe_p[2]);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      if (rnd(2) != 0) drive_push(rnd(WGT), rnd(WGT));
      if (rnd(2) != 0) drive_quad(rnd(256), rnd(256), rnd(256), rnd(256));
      cycle();
      total++;
      if (pixel_out_valid !== pipe_v[2] || (pipe_v[2] && pixel_out !== BPP'(pipe_p[2])))
        $display("FAIL rand_out cyc%0d: got valid=%0b pixel=%0d, want valid=%0b pixel=%0d",
                 c, pixel_out_valid, pixel_out, pipe_v[2], pipe_p[2]);
      else passed++;
      total++;
      if (frac_ready !== (q_x.size() < DEPTH) || err_overflow !== m_ovf || err_underflow !== m_unf)
        $display("FAIL rand_status cyc%0d: got ready=%0b ovf=%0b unf=%0b, want ready=%0b ovf=%0b unf=%0b",
                 c, frac_ready, err_overflow, err_underflow, (q_x.size() < DEPTH), m_ovf, m_unf);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_midpoint();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_back_to_back_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
